key_seq_capture: RTL and testbench

Front-end entry stage. It turns raw push-button presses into the digit sequence shown on the 7-segment display and consumed by the game controller. Each button is synchronized and debounced, then converted to a single press event. Digits are appended as nibbles into `user_seq` and counted in `input_cnt`, which drive the 7-segment display stage directly. Backspace, clear and enter are supported, and a submit handshake hands the finished sequence to the controller.

---
 rtl/key_seq_capture_if.sv | 36 +++
 rtl/key_seq_capture.sv | 272 +++++++++++++++++++++++++++
 tb/tb_key_seq_capture.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_seq_capture_if.sv
// -----------------------------------------------------------------------------
// key_seq_capture_if
// Bundles the raw buttons, the controller handshake and the captured-sequence
// outputs of key_seq_capture. The controller (or a bench) is the master; the
// capture block is the slave.
// -----------------------------------------------------------------------------
interface key_seq_capture_if;

   // Raw buttons, asynchronous to clk, active-high.
   logic [9:0]  key_digit;
   logic        key_bksp;
   logic        key_clr;
   logic        key_enter;

   // Controller handshake.
   logic        capture_en;
   logic        seq_ack;

   // Captured sequence and event strobes.
   logic [31:0] user_seq;
   logic [3:0]  input_cnt;
   logic        seq_valid;
   logic        key_pulse;
   logic        err_pulse;

   modport master (
      output key_digit, key_bksp, key_clr, key_enter, capture_en, seq_ack,
      input  user_seq, input_cnt, seq_valid, key_pulse, err_pulse
   );

   modport slave (
      input  key_digit, key_bksp, key_clr, key_enter, capture_en, seq_ack,
      output user_seq, input_cnt, seq_valid, key_pulse, err_pulse
   );

endinterface

// File: rtl/key_seq_capture.sv
// -----------------------------------------------------------------------------
// key_seq_capture
// Push-button entry stage: synchronizes and debounces 13 raw buttons, turns
// each debounced press into a single event, and builds an up-to-8-digit
// nibble sequence for the display and the game controller.
//
// Optional feature macro: KEY_AUTO_SUBMIT_EN
//   defined   - writing the 8th digit submits the sequence on the same edge.
//   undefined - the sequence stays editable at 8 digits; enter submits.
// -----------------------------------------------------------------------------
module key_seq_capture #(
   parameter int DEBOUNCE_CYCLES = 500000   // sample-tick period, must be >= 2
) (
   input  logic              clk,
   input  logic              rst_n,
   key_seq_capture_if.slave  bus
);

   // -------------------------------------------------------------------------
   // Constants and types
   // -------------------------------------------------------------------------
   localparam int NKEY      = 13;
   localparam int KEY_BKSP  = 10;
   localparam int KEY_CLR   = 11;
   localparam int KEY_ENTER = 12;

   localparam int              PW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0]     SEQ_EMPTY = 32'hFFFF_FFFF;
   localparam logic [3:0]      CNT_FULL  = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_SUBMIT
   } state_t;

   typedef enum logic [2:0] {
      EV_NONE,
      EV_DIGIT,
      EV_BKSP,
      EV_CLR,
      EV_ENTER
   } event_t;

   // -------------------------------------------------------------------------
   // Signals
   // -------------------------------------------------------------------------
   logic [NKEY-1:0] w_raw;
   logic [NKEY-1:0] r_sync1;
   logic [NKEY-1:0] r_sync2;
   logic [NKEY-1:0] r_stable;
   logic [NKEY-1:0] r_press;

   logic [PW-1:0]   r_presc;
   logic            w_tick;

   event_t          w_event;
   logic [3:0]      w_digit;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [31:0]     r_user_seq;
   logic [31:0]     w_seq_nxt;
   logic [3:0]      r_input_cnt;
   logic [3:0]      w_cnt_nxt;
   logic            r_key_pulse;
   logic            w_key_nxt;
   logic            r_err_pulse;
   logic            w_err_nxt;

   logic [2:0]      w_wr_idx;
   logic [2:0]      w_bk_idx;

   // Bit map of the conditioned key vector: [9:0] digits, 10 bksp, 11 clr, 12 enter.
   assign w_raw = {bus.key_enter, bus.key_clr, bus.key_bksp, bus.key_digit};

   // -------------------------------------------------------------------------
   // Input conditioning
   // -------------------------------------------------------------------------

   // Two-flop synchronizer for every raw button.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, exactly like the hardware does.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Free-running prescaler; the wrap cycle is the debounce sample tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (r_presc == PRESC_MAX) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   assign w_tick = (r_presc == PRESC_MAX);

   // Sample the synchronized keys once per tick and flag new rising levels.
   // Bounces that come and go between two ticks never reach r_stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable <= '0;
         r_press  <= '0;
      end else if (w_tick) begin
         r_stable <= r_sync2;
         r_press  <= r_sync2 & ~r_stable;
      end else begin
         r_press  <= '0;
      end
   end

   // -------------------------------------------------------------------------
   // Press arbitration: one event per tick, clr > bksp > enter > lowest digit
   // -------------------------------------------------------------------------

   // Pick the single winning event out of the press vector.
   // NOTE: every variable driven here gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      w_event = EV_NONE;
      w_digit = 4'd0;
      if (r_press[KEY_CLR]) begin
         w_event = EV_CLR;
      end else if (r_press[KEY_BKSP]) begin
         w_event = EV_BKSP;
      end else if (r_press[KEY_ENTER]) begin
         w_event = EV_ENTER;
      end else if (|r_press[9:0]) begin
         w_event = EV_DIGIT;
         // Scan downward so the lowest pressed index is the last one written.
         for (int i = 9; i >= 0; i--) begin
            if (r_press[i]) begin
               w_digit = 4'(i);
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Entry FSM
   // -------------------------------------------------------------------------

   // Nibble slots for the next digit write and for backspace removal.
   assign w_wr_idx = r_input_cnt[2:0];
   assign w_bk_idx = r_input_cnt[2:0] - 3'd1;

   // Next state, next sequence contents and next pulse values.
   always_comb begin
      w_state_nxt = r_state;
      w_seq_nxt   = r_user_seq;
      w_cnt_nxt   = r_input_cnt;
      w_key_nxt   = 1'b0;
      w_err_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Keys are ignored; a fresh entry always starts from an empty buffer.
            if (bus.capture_en) begin
               w_state_nxt = S_ENTRY;
               w_seq_nxt   = SEQ_EMPTY;
               w_cnt_nxt   = 4'd0;
            end
         end

         S_ENTRY: begin
            if (!bus.capture_en) begin
               // Losing permission wins over any key event in the same cycle.
               w_state_nxt = S_IDLE;
            end else begin
               case (w_event)
                  EV_DIGIT: begin
                     if (r_input_cnt < CNT_FULL) begin
                        w_seq_nxt[{w_wr_idx, 2'b00} +: 4] = w_digit;
                        w_cnt_nxt = r_input_cnt + 4'd1;
                        w_key_nxt = 1'b1;
`ifdef KEY_AUTO_SUBMIT_EN
                        // The 8th digit completes the entry without enter.
                        if (r_input_cnt == CNT_FULL - 4'd1) begin
                           w_state_nxt = S_SUBMIT;
                        end
`else
                        // A full buffer stays editable until enter is pressed.
                        w_state_nxt = S_ENTRY;
`endif
                     end else begin
                        w_err_nxt = 1'b1;
                     end
                  end

                  EV_BKSP: begin
                     if (r_input_cnt != 4'd0) begin
                        w_seq_nxt[{w_bk_idx, 2'b00} +: 4] = 4'hF;
                        w_cnt_nxt = r_input_cnt - 4'd1;
                        w_key_nxt = 1'b1;
                     end else begin
                        w_err_nxt = 1'b1;
                     end
                  end

                  EV_CLR: begin
                     // Clearing an already empty buffer still counts as accepted.
                     w_seq_nxt = SEQ_EMPTY;
                     w_cnt_nxt = 4'd0;
                     w_key_nxt = 1'b1;
                  end

                  EV_ENTER: begin
                     if (r_input_cnt != 4'd0) begin
                        w_state_nxt = S_SUBMIT;
                        w_key_nxt   = 1'b1;
                     end else begin
                        w_err_nxt = 1'b1;
                     end
                  end

                  default: begin
                     // No event this cycle.
                  end
               endcase
            end
         end

         S_SUBMIT: begin
            // Contents frozen, keys ignored; the ack releases the sequence.
            if (bus.seq_ack) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, sequence buffer and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_user_seq  <= SEQ_EMPTY;
         r_input_cnt <= 4'd0;
         r_key_pulse <= 1'b0;
         r_err_pulse <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_user_seq  <= w_seq_nxt;
         r_input_cnt <= w_cnt_nxt;
         r_key_pulse <= w_key_nxt;
         r_err_pulse <= w_err_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: all come straight from registers
   // -------------------------------------------------------------------------
   assign bus.user_seq  = r_user_seq;
   assign bus.input_cnt = r_input_cnt;
   assign bus.seq_valid = (r_state == S_SUBMIT);
   assign bus.key_pulse = r_key_pulse;
   assign bus.err_pulse = r_err_pulse;

endmodule

// File: tb/tb_key_seq_capture.sv
// -----------------------------------------------------------------------------
// tb_key_seq_capture
// Directed and randomized button sequences for key_seq_capture with
// DEBOUNCE_CYCLES = 4. Expected contents come from a reference model that
// keeps the entered digits as a queue and applies the entry rules per press.
// -----------------------------------------------------------------------------
module tb_key_seq_capture;

   localparam int DEB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   key_seq_capture_if bus ();

   key_seq_capture #(
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // -------------------------------------------------------------------------
   // Bookkeeping
   // -------------------------------------------------------------------------
   int n_vec = 0;
   int n_mis = 0;
   int n_kp  = 0;   // key_pulse cycles seen
   int n_ep  = 0;   // err_pulse cycles seen
   int tb_phase;    // clock cycles since reset, modulo DEB

   always @(negedge clk) begin
      if (bus.key_pulse === 1'b1) n_kp <= n_kp + 1;
      if (bus.err_pulse === 1'b1) n_ep <= n_ep + 1;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_phase <= 0;
      else        tb_phase <= (tb_phase + 1) % DEB;
   end

   // -------------------------------------------------------------------------
   // Reference model: digits as a queue, mode as a three-way label
   // -------------------------------------------------------------------------
   typedef enum {M_IDLE, M_ENTRY, M_SUBMIT} mode_t;
   mode_t m_mode;
   int    m_digits[$];

   function automatic logic [31:0] m_seq();
      logic [31:0] s;
      s = 32'hFFFF_FFFF;
      foreach (m_digits[i]) s[i*4 +: 4] = 4'(m_digits[i]);
      return s;
   endfunction

   // Applies one debounced press (mask bit 12 enter, 11 clr, 10 bksp, 9:0 digits).
   task automatic m_apply(input logic [12:0] mask, output int ek, output int ee);
      int d;
      ek = 0;
      ee = 0;
      if (m_mode != M_ENTRY || mask == '0) return;
      if (mask[11]) begin
         m_digits.delete();
         ek = 1;
      end else if (mask[10]) begin
         if (m_digits.size() > 0) begin
            void'(m_digits.pop_back());
            ek = 1;
         end else ee = 1;
      end else if (mask[12]) begin
         if (m_digits.size() >= 1) begin
            m_mode = M_SUBMIT;
            ek = 1;
         end else ee = 1;
      end else begin
         d = 0;
         while (!mask[d]) d++;
         if (m_digits.size() < 8) begin
            m_digits.push_back(d);
            ek = 1;
`ifdef KEY_AUTO_SUBMIT_EN
            if (m_digits.size() == 8) m_mode = M_SUBMIT;
`endif
         end else ee = 1;
      end
   endtask

   // -------------------------------------------------------------------------
   // Checking helpers
   // -------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, " seq"},   bus.user_seq, m_seq());
      check({tag, " cnt"},   32'(bus.input_cnt), 32'(m_digits.size()));
      check({tag, " valid"}, 32'(bus.seq_valid), (m_mode == M_SUBMIT) ? 32'd1 : 32'd0);
   endtask

   task automatic set_keys(input logic [12:0] mask);
      {bus.key_enter, bus.key_clr, bus.key_bksp, bus.key_digit} = mask;
   endtask

   // Hold a key pattern, release it, then compare pulses and contents.
   task automatic press(input logic [12:0] mask, input int hold, input string tag);
      int k0, e0, ek, ee;
      k0 = n_kp;
      e0 = n_ep;
      @(negedge clk);
      set_keys(mask);
      repeat (hold) @(negedge clk);
      set_keys('0);
      repeat (8) @(negedge clk);
      m_apply(mask, ek, ee);
      check({tag, " kp"}, 32'(n_kp - k0), 32'(ek));
      check({tag, " ep"}, 32'(n_ep - e0), 32'(ee));
      check_state(tag);
   endtask

   function automatic logic [12:0] dig(input int d);
      logic [12:0] m;
      m = '0;
      m[d] = 1'b1;
      return m;
   endfunction

   localparam logic [12:0] K_BKSP  = 13'h0400;
   localparam logic [12:0] K_CLR   = 13'h0800;
   localparam logic [12:0] K_ENTER = 13'h1000;

   // One-cycle ack; valid must drop on the next edge with contents retained,
   // and with capture_en high the buffer is cleared one cycle later.
   task automatic do_ack(input string tag);
      @(negedge clk);
      bus.seq_ack = 1'b1;
      @(negedge clk);
      bus.seq_ack = 1'b0;
      if (m_mode == M_SUBMIT) m_mode = M_IDLE;
      check_state({tag, " ack"});
      @(negedge clk);
      if (m_mode == M_IDLE && bus.capture_en) begin
         m_mode = M_ENTRY;
         m_digits.delete();
      end
      check_state({tag, " post"});
   endtask

   // -------------------------------------------------------------------------
   // Watchdog
   // -------------------------------------------------------------------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      int k0, e0, r, hold;
      logic [12:0] mask;

      set_keys('0);
      bus.capture_en = 1'b0;
      bus.seq_ack    = 1'b0;
      m_mode = M_IDLE;

      // Reset values while held in reset.
      #12;
      check("rst seq",   bus.user_seq, 32'hFFFF_FFFF);
      check("rst cnt",   32'(bus.input_cnt), 32'd0);
      check("rst valid", 32'(bus.seq_valid), 32'd0);
      check("rst kp",    32'(bus.key_pulse), 32'd0);
      check("rst ep",    32'(bus.err_pulse), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Keys in IDLE are ignored.
      press(dig(7), 8, "idle key");

      // Start entry.
      @(negedge clk);
      bus.capture_en = 1'b1;
      m_mode = M_ENTRY;
      m_digits.delete();
      repeat (2) @(negedge clk);
      check_state("enter entry");

      // Digit entry 3,1,4; the 4 is held for 40 cycles.
      k0 = n_kp;
      press(dig(3), 8, "d3");
      press(dig(1), 8, "d1");
      press(dig(4), 40, "d4 long");
      check("seq 314",   bus.user_seq, 32'hFFFF_F413);
      check("cnt 314",   32'(bus.input_cnt), 32'd3);
      check("kp 314",    32'(n_kp - k0), 32'd3);

      // Backspace, clear, backspace on empty.
      press(K_BKSP, 8, "bksp");
      check("seq bksp", bus.user_seq, 32'hFFFF_FF13);
      press(K_CLR, 8, "clr");
      check("seq clr",  bus.user_seq, 32'hFFFF_FFFF);
      press(K_BKSP, 8, "bksp empty");
      press(K_CLR, 8, "clr empty");
      press(K_ENTER, 8, "enter empty");

      // Fill the buffer with 1..8.
      for (int d = 1; d <= 8; d++) press(dig(d), 8, "fill");
      check("seq full", bus.user_seq, 32'h8765_4321);
      check("cnt full", 32'(bus.input_cnt), 32'd8);
`ifdef KEY_AUTO_SUBMIT_EN
      check("auto valid", 32'(bus.seq_valid), 32'd1);
`endif
      press(dig(9), 8, "d9 full");
      press(K_ENTER, 8, "enter full");
      press(dig(5), 8, "d5 submit");
      do_ack("full");

      // Submit with two digits.
      press(dig(1), 8, "s1");
      press(dig(2), 8, "s2");
      press(K_ENTER, 8, "enter2");
      check("valid cnt2", 32'(bus.seq_valid), 32'd1);
      press(dig(3), 8, "ignored in submit");
      do_ack("cnt2");

      // Ack outside SUBMIT is ignored.
      do_ack("stray");

      // Simultaneous presses.
      press(dig(5) | dig(2), 8, "d5+d2");
      check("seq d2", bus.user_seq, 32'hFFFF_FFF2);
      press(K_CLR | dig(7), 8, "clr+d7");
      check("seq clr+d", bus.user_seq, 32'hFFFF_FFFF);
      press(K_ENTER | K_BKSP, 8, "enter+bksp");

      // One-cycle glitch that lands between ticks.
      press(dig(6), 8, "pre glitch");
      for (int i = 0; i < 2 * DEB && tb_phase != DEB - 1; i++) @(negedge clk);
      k0 = n_kp;
      e0 = n_ep;
      bus.key_digit[8] = 1'b1;
      @(negedge clk);
      bus.key_digit[8] = 1'b0;
      repeat (16) @(negedge clk);
      check("glitch kp", 32'(n_kp - k0), 32'd0);
      check("glitch ep", 32'(n_ep - e0), 32'd0);
      check_state("glitch");

      // Dropping capture_en keeps contents; re-enabling clears them.
      @(negedge clk);
      bus.capture_en = 1'b0;
      m_mode = M_IDLE;
      repeat (2) @(negedge clk);
      check_state("cap off");
      press(dig(4), 8, "cap off key");
      @(negedge clk);
      bus.capture_en = 1'b1;
      m_mode = M_ENTRY;
      m_digits.delete();
      repeat (2) @(negedge clk);
      check_state("cap on");

      // Randomized presses against the model.
      for (int it = 0; it < 60; it++) begin
         if (m_mode == M_SUBMIT) begin
            if ($urandom_range(0, 1) == 1) press(dig($urandom_range(0, 9)), 8, "rnd submit");
            do_ack("rnd");
         end
         r = $urandom_range(0, 99);
         if (r < 55)      mask = dig($urandom_range(0, 9));
         else if (r < 68) mask = K_BKSP;
         else if (r < 73) mask = K_CLR;
         else if (r < 85) mask = K_ENTER;
         else             mask = 13'($urandom_range(1, 8191));
         hold = $urandom_range(8, 20);
         press(mask, hold, "rnd");
      end

      // Asynchronous reset mid-entry, with no clock edge before the check.
      press(K_CLR, 8, "pre rst");
      if (m_mode == M_SUBMIT) do_ack("pre rst");
      press(dig(3), 8, "r3");
      press(dig(1), 8, "r1");
      press(dig(4), 8, "r4");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_mode = M_IDLE;
      m_digits.delete();
      check("mid rst seq",   bus.user_seq, 32'hFFFF_FFFF);
      check("mid rst cnt",   32'(bus.input_cnt), 32'd0);
      check("mid rst valid", 32'(bus.seq_valid), 32'd0);
      check("mid rst kp",    32'(bus.key_pulse), 32'd0);
      check("mid rst ep",    32'(bus.err_pulse), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_mode = M_ENTRY;
      repeat (2) @(negedge clk);
      check_state("after rst");
      press(dig(9), 8, "after rst d9");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
